mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle main control FSM for the RV32I-subset CPU core. Sequences the shared ALU, register file and unified instruction/data memory across fetch, decode, execute, memory and writeback steps. Drives the 2-bit `aluop` consumed by the ALU control decoder, plus all datapath mux selects and write enables. Holds a ready/valid-style wait on the memory port so that variable-latency memory stalls the sequence.

## Interface
Parameters: none. All encodings are fixed in `mc_ctrl_pkg`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current request this cycle.
- `mem_req` out 1: memory request valid.
- `mem_write` out 1: request is a store.
- `adr_src` out 1: memory address select. 0 = PC; 1 = ALUOut register.
- `ir_write` out 1: load IR and OldPC.
- `pc_write` out 1: PC load enable. Equal to `pc_update | (branch & zero)`.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: A-operand select. 00 = PC; 01 = OldPC; 10 = rs1 register.
- `alu_src_b` out 2: B-operand select. 00 = rs2 register; 01 = immediate; 10 = constant 4.
- `aluop` out 2: 00 = add; 01 = subtract; 10 = decode from funct3/funct7.
- `funct7_en` out 1: datapath ANDs `instr[30]` with this before feeding the ALU control.
- `result_src` out 2: result select. 00 = ALUOut; 01 = memory data register; 10 = live ALU result.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `state_dbg` out 4: current state encoding.

## Operation
States and transitions. Each line gives the asserted outputs; every unlisted output is 0.
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `aluop`=00, `result_src`=10. On `mem_ready`: `ir_write`=1 and `pc_update`=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `aluop`=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Any other opcode → FETCH, with `illegal`=1.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `aluop`=00. Go to MEMREAD if the opcode is a load, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Go to FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Wait for `mem_ready`, then go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `aluop`=10, `funct7_en`=1. Go to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `aluop`=10, `funct7_en`=0. Go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Go to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `aluop`=01, `result_src`=00, `branch`=1. Go to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `aluop`=00, `result_src`=00, `pc_update`=1. Go to ALUWB (writes PC+4 to rd).

Memory handshake rules:
- While waiting in FETCH, MEMREAD or MEMWRITE, `mem_req`, `mem_write` and `adr_src` hold stable.
- `ir_write` and `pc_write` remain 0 until the `mem_ready` cycle.
- `mem_ready` sampled outside those three states is ignored.

## Timing
- Outputs are Moore-style from the state register. Exceptions: `ir_write`, `pc_write` and the FETCH exit, which are qualified combinationally by `mem_ready` and `zero`.
- Reset:
  - While `rst`=1, every output is 0, including `mem_req`, and `state_dbg`=0.
  - The edge that samples `rst`=1 loads FETCH (encoding 0).
  - The first request appears in the cycle after `rst` falls.
- Reset mid-operation: any state, including a pending memory wait, goes to FETCH with no write enable asserted.
- Instruction latency with zero-wait memory (`mem_ready` held 1):
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - illegal: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- `mem_ready` in the same cycle as the request completes it. No minimum wait.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10;
  - opcode constants;
  - `alu_src_a`, `alu_src_b`, `result_src` and `aluop` encodings.
- `mc_ctrl_decode` is a combinational sub-module: state plus `mem_ready` → control outputs.
- The top level holds the state register, the next-state logic and the `pc_write` OR/AND term.

## Test plan
- Reset: hold `rst`=1 for 3 cycles mid-MEMREAD wait → all outputs 0 and `state_dbg`=0. First FETCH `mem_req`=1 the cycle after release.
- lw (opcode 0000011) with `mem_ready` low 2 cycles in FETCH and 1 cycle in MEMREAD → state sequence 0,0,0,1,2,3,3,4,0. `reg_write`=1 only in state 4.
- sw (0100011), zero-wait → `mem_write`=1 and `adr_src`=1 exactly 1 cycle. `reg_write` never asserted.
- R-type then I-type → EXECR gives `aluop`=10, `funct7_en`=1. EXECI gives `aluop`=10, `funct7_en`=0. Each 4 cycles.
- beq (1100011) with `zero`=1, then with `zero`=0 → `pc_write`=1 in BEQ only when taken. `aluop`=01.
- Opcode 1111111 → `illegal`=1 for exactly one cycle in DECODE, then back to FETCH. No write enables asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } mc_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Per-state control word. Only FETCH looks at mem_ready, so its strobes
// fire in the completion cycle and nowhere else.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  mc_state_t  state,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       funct7_en,
  output logic [1:0] result_src
);

  // Moore outputs per state, with the FETCH strobes qualified by mem_ready
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    aluop      = ALUOP_ADD;
    funct7_en  = 1'b0;
    result_src = RES_ALUOUT;
    unique case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        aluop      = ALUOP_ADD;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_FUNCT;
        funct7_en = 1'b1;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main control FSM: state register, next-state logic, PC write term.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 computed; wait for mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | rs1 + imm into ALUOut
// MEMREAD  | load read at ALUOut; wait for mem_ready
// MEMWB    | write memory data register to rd
// MEMWRITE | store at ALUOut; wait for mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, load PC from ALUOut when equal
// JAL      | PC from ALUOut, OldPC+4 computed for the link write
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       funct7_en,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  mc_state_t  state_q, state_n;
  logic       illegal_n;

  logic       d_mem_req, d_mem_write, d_adr_src, d_ir_write;
  logic       d_pc_update, d_branch, d_reg_write, d_funct7_en;
  logic [1:0] d_alu_src_a, d_alu_src_b, d_aluop, d_result_src;

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .mem_req    (d_mem_req),
    .mem_write  (d_mem_write),
    .adr_src    (d_adr_src),
    .ir_write   (d_ir_write),
    .pc_update  (d_pc_update),
    .branch     (d_branch),
    .reg_write  (d_reg_write),
    .alu_src_a  (d_alu_src_a),
    .alu_src_b  (d_alu_src_b),
    .aluop      (d_aluop),
    .funct7_en  (d_funct7_en),
    .result_src (d_result_src)
  );

  // State register; synchronous reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_n;
  end

  // Next state; memory states hold until mem_ready, unknown opcodes flag illegal
  always_comb begin
    state_n   = state_q;
    illegal_n = 1'b0;
    unique case (state_q)
      FETCH:    if (mem_ready) state_n = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_RTYPE:          state_n = EXECR;
          OP_ITYPE:          state_n = EXECI;
          OP_BEQ:            state_n = BEQ;
          OP_JAL:            state_n = JAL;
          default: begin
            state_n   = FETCH;
            illegal_n = 1'b1;
          end
        endcase
      end
      MEMADR:   state_n = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (mem_ready) state_n = FETCH;
      EXECR:    state_n = ALUWB;
      EXECI:    state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BEQ:      state_n = FETCH;
      JAL:      state_n = ALUWB;
      default:  state_n = FETCH;
    endcase
  end

  // Outputs forced quiet for the whole time rst is high, even before the
  // reset edge has moved the state register back to FETCH
  always_comb begin
    mem_req    = d_mem_req    & ~rst;
    mem_write  = d_mem_write  & ~rst;
    adr_src    = d_adr_src    & ~rst;
    ir_write   = d_ir_write   & ~rst;
    pc_write   = (d_pc_update | (d_branch & zero)) & ~rst;
    reg_write  = d_reg_write  & ~rst;
    alu_src_a  = rst ? 2'b00 : d_alu_src_a;
    alu_src_b  = rst ? 2'b00 : d_alu_src_b;
    aluop      = rst ? 2'b00 : d_aluop;
    funct7_en  = d_funct7_en  & ~rst;
    result_src = rst ? 2'b00 : d_result_src;
    illegal    = illegal_n    & ~rst;
    state_dbg  = rst ? 4'd0 : state_q;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state and packed control word checks.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, aluop, result_src;
  logic       funct7_en, illegal;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //  alu_src_a, alu_src_b, aluop, funct7_en, result_src, illegal}
  logic [15:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, aluop, funct7_en, result_src, illegal};

  localparam logic [15:0] O_NONE     = 16'h0000;
  localparam logic [15:0] O_FETCH_W  = 16'h8084;
  localparam logic [15:0] O_FETCH_R  = 16'h9884;
  localparam logic [15:0] O_DECODE   = 16'h0140;
  localparam logic [15:0] O_DEC_ILL  = 16'h0141;
  localparam logic [15:0] O_MEMADR   = 16'h0240;
  localparam logic [15:0] O_MEMREAD  = 16'hA000;
  localparam logic [15:0] O_MEMWB    = 16'h0402;
  localparam logic [15:0] O_MEMWRITE = 16'hE000;
  localparam logic [15:0] O_EXECR    = 16'h0228;
  localparam logic [15:0] O_EXECI    = 16'h0260;
  localparam logic [15:0] O_ALUWB    = 16'h0400;
  localparam logic [15:0] O_BEQ_T    = 16'h0A10;
  localparam logic [15:0] O_BEQ_N    = 16'h0210;
  localparam logic [15:0] O_JAL      = 16'h0980;

  mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .funct7_en  (funct7_en),
    .result_src (result_src),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive mem_ready, sample at the falling edge, then step
  // to just after the next rising edge.
  task automatic cyc(input string tag, input logic rdy,
                     input logic [3:0] exp_state, input logic [15:0] exp_out);
    mem_ready = rdy;
    @(negedge clk);
    checks++;
    assert (state_dbg === exp_state)
      else begin
        errors++;
        $error("FAIL %s state observed %0d expected %0d", tag, state_dbg, exp_state);
      end
    checks++;
    assert (obs === exp_out)
      else begin
        errors++;
        $error("FAIL %s ctrl observed %h expected %h", tag, obs, exp_out);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("por0", 1'b0, 4'd0, O_NONE);
    cyc("por1", 1'b1, 4'd0, O_NONE);
    rst = 1'b0;

    // lw with two FETCH waits and one MEMREAD wait
    opcode = 7'b0000011;
    cyc("lw_f0", 1'b0, 4'd0, O_FETCH_W);
    cyc("lw_f1", 1'b0, 4'd0, O_FETCH_W);
    cyc("lw_f2", 1'b1, 4'd0, O_FETCH_R);
    cyc("lw_dec", 1'b1, 4'd1, O_DECODE);
    cyc("lw_adr", 1'b1, 4'd2, O_MEMADR);
    cyc("lw_rd0", 1'b0, 4'd3, O_MEMREAD);
    cyc("lw_rd1", 1'b1, 4'd3, O_MEMREAD);
    cyc("lw_wb", 1'b0, 4'd4, O_MEMWB);

    // lw again, reset applied during the MEMREAD wait
    cyc("rlw_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("rlw_dec", 1'b0, 4'd1, O_DECODE);
    cyc("rlw_adr", 1'b0, 4'd2, O_MEMADR);
    cyc("rlw_rd", 1'b0, 4'd3, O_MEMREAD);
    rst = 1'b1;
    cyc("rst0", 1'b0, 4'd0, O_NONE);
    cyc("rst1", 1'b1, 4'd0, O_NONE);
    cyc("rst2", 1'b0, 4'd0, O_NONE);
    rst = 1'b0;
    cyc("rel_f", 1'b0, 4'd0, O_FETCH_W);

    // sw, zero-wait
    opcode = 7'b0100011;
    cyc("sw_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("sw_dec", 1'b1, 4'd1, O_DECODE);
    cyc("sw_adr", 1'b1, 4'd2, O_MEMADR);
    cyc("sw_wr", 1'b1, 4'd5, O_MEMWRITE);

    // R-type
    opcode = 7'b0110011;
    cyc("r_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("r_dec", 1'b1, 4'd1, O_DECODE);
    cyc("r_ex", 1'b1, 4'd6, O_EXECR);
    cyc("r_wb", 1'b1, 4'd8, O_ALUWB);

    // I-type
    opcode = 7'b0010011;
    cyc("i_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("i_dec", 1'b1, 4'd1, O_DECODE);
    cyc("i_ex", 1'b1, 4'd7, O_EXECI);
    cyc("i_wb", 1'b1, 4'd8, O_ALUWB);

    // beq taken: zero high in DECODE must not write PC
    opcode = 7'b1100011;
    zero = 1'b1;
    cyc("bt_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("bt_dec", 1'b1, 4'd1, O_DECODE);
    cyc("bt_beq", 1'b1, 4'd9, O_BEQ_T);

    // beq not taken
    zero = 1'b0;
    cyc("bn_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("bn_dec", 1'b1, 4'd1, O_DECODE);
    cyc("bn_beq", 1'b1, 4'd9, O_BEQ_N);

    // jal
    opcode = 7'b1101111;
    cyc("j_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("j_dec", 1'b1, 4'd1, O_DECODE);
    cyc("j_jal", 1'b1, 4'd10, O_JAL);
    cyc("j_wb", 1'b1, 4'd8, O_ALUWB);

    // illegal opcode: one-cycle pulse then back to FETCH
    opcode = 7'b1111111;
    cyc("il_f", 1'b1, 4'd0, O_FETCH_R);
    cyc("il_dec", 1'b1, 4'd1, O_DEC_ILL);
    cyc("il_back", 1'b0, 4'd0, O_FETCH_W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
